// File: rtl/read_index_ctrl.sv
// Read-side index controller for a CNT_MAX-deep circular buffer.
// Mirrors the writer index from wr_inc pulses, presents the next unread
// index to a consumer, tracks occupancy, flags dropped writes and pulses
// frame_done after the last index of a frame has been consumed.
//
// Handshake: rd_valid means rd_addr holds an unread entry. A read occurs
// on a rising edge where rd_valid & rd_ready are both 1. rd_valid is a
// function of registered occupancy only, so it never depends on rd_ready
// or wr_inc in the same cycle. rd_ready while rd_valid=0 has no effect.
module read_index_ctrl #(
  parameter int WIDTH   = 8,
  parameter int CNT_MAX = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_inc,
  input  logic             rd_ready,
  input  logic             clr_err,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_addr,
  output logic             rd_last,
  output logic             frame_done,
  output logic [WIDTH:0]   occupancy,
  output logic             full,
  output logic             empty,
  output logic             ovf_err,
  output logic             state_dbg
);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  // Highest index and full-level count; occupancy is one bit wider than
  // the pointers so CNT_MAX == 2**WIDTH is representable without wrap.
  localparam logic [WIDTH-1:0] LAST_IDX = WIDTH'(CNT_MAX - 1);
  localparam logic [WIDTH:0]   OCC_MAX  = (WIDTH + 1)'(CNT_MAX);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] wr_ptr;
  logic             rd_fire;
  logic             wr_acc;
  logic             wr_drop;

  assign empty     = (occupancy == '0);
  assign full      = (occupancy == OCC_MAX);
  assign rd_valid  = !empty;
  assign rd_last   = (rd_addr == LAST_IDX);
  assign state_dbg = state;

  // A full buffer still takes a write when a read frees a slot this cycle.
  assign rd_fire = rd_valid & rd_ready;
  assign wr_acc  = wr_inc & (!full | rd_fire);
  assign wr_drop = wr_inc & full & !rd_fire;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state: IDLE tracks empty, STREAM tracks non-empty
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (wr_acc) state_nxt = STREAM;
      STREAM: if (rd_fire && !wr_acc && occupancy == (WIDTH + 1)'(1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Write pointer mirrors the writer index on each accepted write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      wr_ptr <= '0;
    else if (wr_acc) wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + 1'b1;
  end

  // Read pointer advances on each read handshake, wrapping at the last index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       rd_addr <= '0;
    else if (rd_fire) rd_addr <= (rd_addr == LAST_IDX) ? '0 : rd_addr + 1'b1;
  end

  // Occupancy: +1 on write only, -1 on read only, otherwise hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occupancy <= '0;
    end else begin
      case ({wr_acc, rd_fire})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end

  // frame_done pulses the cycle after the last index of a frame is read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_done <= 1'b0;
    else        frame_done <= rd_fire & rd_last;
  end

  // Sticky overflow flag; a drop in the same cycle as clr_err keeps it set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ovf_err <= 1'b0;
    else if (wr_drop) ovf_err <= 1'b1;
    else if (clr_err) ovf_err <= 1'b0;
  end

endmodule

// File: tb/tb_read_index_ctrl.sv
// Bench for read_index_ctrl (WIDTH=8, CNT_MAX=8): directed scenarios
// followed by randomized traffic. A reference model holds the unread
// entries as a queue of buffer indices; a monitor checks every read
// handshake against the expected-index queue.
module tb_read_index_ctrl;
  localparam int WIDTH   = 8;
  localparam int CNT_MAX = 8;

  logic             clk;
  logic             rst_n;
  logic             wr_inc;
  logic             rd_ready;
  logic             clr_err;
  logic             rd_valid;
  logic [WIDTH-1:0] rd_addr;
  logic             rd_last;
  logic             frame_done;
  logic [WIDTH:0]   occupancy;
  logic             full;
  logic             empty;
  logic             ovf_err;
  logic             state_dbg;

  read_index_ctrl #(.WIDTH(WIDTH), .CNT_MAX(CNT_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .wr_inc(wr_inc), .rd_ready(rd_ready),
    .clr_err(clr_err), .rd_valid(rd_valid), .rd_addr(rd_addr),
    .rd_last(rd_last), .frame_done(frame_done), .occupancy(occupancy),
    .full(full), .empty(empty), .ovf_err(ovf_err), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard / model state ----------------
  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] exp_q[$];   // indices the monitor expects to see read
  int mq[$];                    // model: unread entries, oldest first
  int m_wr_idx;                 // model: writer's next index
  bit m_ovf;
  bit m_fd;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    m_wr_idx = 0;
    m_ovf    = 1'b0;
    m_fd     = 1'b0;
  endtask

  // Advance the model across one rising edge for the given inputs.
  task automatic model_step(input bit wr, input bit rd, input bit clr);
    bit fire;
    bit was_full;
    int popped;
    was_full = (mq.size() == CNT_MAX);
    fire     = (mq.size() > 0) && rd;
    m_fd     = 1'b0;
    if (fire) begin
      popped = mq.pop_front();
      m_fd   = (popped == CNT_MAX - 1);
    end
    if (wr) begin
      if (!was_full || fire) begin
        mq.push_back(m_wr_idx);
        exp_q.push_back(m_wr_idx[WIDTH-1:0]);
        m_wr_idx = (m_wr_idx + 1) % CNT_MAX;
      end else begin
        m_ovf = 1'b1;
      end
    end else if (clr) begin
      m_ovf = 1'b0;
    end
    if (wr && was_full && !fire) m_ovf = 1'b1;
    else if (clr && !(wr && was_full && !fire)) m_ovf = 1'b0;
  endtask

  task automatic check_outputs();
    int occ;
    int ea;
    occ = mq.size();
    ea  = (occ > 0) ? mq[0] : m_wr_idx;
    chk("occupancy",  int'(occupancy),  occ);
    chk("rd_valid",   int'(rd_valid),   int'(occ > 0));
    chk("rd_addr",    int'(rd_addr),    ea);
    chk("rd_last",    int'(rd_last),    int'(ea == CNT_MAX - 1));
    chk("full",       int'(full),       int'(occ == CNT_MAX));
    chk("empty",      int'(empty),      int'(occ == 0));
    chk("frame_done", int'(frame_done), int'(m_fd));
    chk("ovf_err",    int'(ovf_err),    int'(m_ovf));
    chk("state_dbg",  int'(state_dbg),  int'(occ > 0));
  endtask

  // ---------------- driver tasks ----------------
  // Called just after a rising edge: drive inputs, step the model, then
  // check the outputs just after the next rising edge.
  task automatic cycle(input bit wr, input bit rd, input bit clr);
    wr_inc   = wr;
    rd_ready = rd;
    clr_err  = clr;
    model_step(wr, rd, clr);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  // Assert reset asynchronously mid-cycle, check the immediate effect,
  // then release on a falling edge with wr_inc = wr_first so the first
  // edge after release is exercised.
  task automatic do_reset(input bit wr_first);
    rst_n = 1'b0;
    #2;
    model_reset();
    check_outputs();
    wr_inc   = 1'b0;
    rd_ready = 1'b0;
    clr_err  = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
    wr_inc = wr_first;
    model_step(wr_first, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  // ---------------- monitor ----------------
  // Every read handshake must consume the oldest expected index.
  always @(negedge clk) begin
    if (rst_n && rd_valid && rd_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_read: got read of %0d expected no read at %0t", rd_addr, $time);
      end else begin
        logic [WIDTH-1:0] e;
        e = exp_q.pop_front();
        chk("sb_rd_addr", int'(rd_addr), int'(e));
        chk("sb_rd_last", int'(rd_last), int'(e == WIDTH'(CNT_MAX - 1)));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n    = 1'b0;
    wr_inc   = 1'b0;
    rd_ready = 1'b0;
    clr_err  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset(1'b0);

    // Fill three, then drain three.
    repeat (3) cycle(1'b1, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, 1'b1, 1'b0);

    // Overflow: nine writes into an eight-deep buffer, then clear.
    repeat (9) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);
    // Drop together with clr_err: set wins.
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);

    // At full, write and read together: occupancy holds, no error.
    cycle(1'b1, 1'b1, 1'b0);
    repeat (CNT_MAX + 1) cycle(1'b0, 1'b1, 1'b0);

    // Wrap and frame boundary; first write lands on the first edge after reset.
    do_reset(1'b1);
    repeat (9) cycle(1'b1, 1'b1, 1'b0);
    repeat (3) cycle(1'b0, 1'b1, 1'b0);

    // Empty buffer with write and ready together: no same-cycle read.
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);

    // Back-pressure at occupancy 4.
    do_reset(1'b0);
    repeat (4) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);

    // Reset mid-operation at occupancy 5, rd_addr 3.
    do_reset(1'b0);
    repeat (8) cycle(1'b1, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, 1'b1, 1'b0);
    rd_ready = 1'b1;
    do_reset(1'b0);
    repeat (2) cycle(1'b0, 1'b1, 1'b0);

    // Randomized traffic with shifting write/read bias and rare resets.
    for (int ph = 0; ph < 4; ph++) begin
      int wr_pct;
      int rd_pct;
      wr_pct = (ph % 2 == 0) ? 75 : 35;
      rd_pct = (ph % 2 == 0) ? 35 : 75;
      for (int i = 0; i < 200; i++) begin
        if ($urandom_range(0, 199) == 0) begin
          do_reset(1'($urandom_range(0, 1)));
        end else begin
          cycle(1'($urandom_range(0, 99) < wr_pct),
                1'($urandom_range(0, 99) < rd_pct),
                1'($urandom_range(0, 99) < 6));
        end
      end
    end

    // Drain and confirm every expected read was observed.
    repeat (CNT_MAX + 2) cycle(1'b0, 1'b1, 1'b0);
    chk("sb_drain", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
